// File: rtl/reator_pkg.sv
// Shared types, default parameters and helpers for the reactor temperature monitor.
package reator_pkg;

  localparam int W_DEF      = 9;
  localparam int DEPTH_DEF  = 4;
  localparam int LIMIAR_DEF = 300;
  localparam int HIST_DEF   = 20;
  localparam int N_ESC_DEF  = 2;

  typedef enum logic [2:0] {
    NORMAL     = 3'd0,
    REFRIG     = 3'd1,
    PORTAS     = 3'd2,
    ALARME     = 3'd3,
    RESFRIANDO = 3'd4
  } estado_t;

  // Ceiling log2; exact for the power-of-two window depths used here.
  function automatic int log2c(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/janela_media.sv
// Sliding window of DEPTH samples with a running sum, giving an exact moving average.
module janela_media
  import reator_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         CLOCK,
  input  logic         reset,
  input  logic         amostraValida,
  input  logic [W-1:0] tempRea,
  output logic [W-1:0] media,
  output logic         mediaValida,
  output logic         janelaCheia
);

  localparam int LD = log2c(DEPTH);
  localparam int SW = W + LD;
  localparam logic [LD:0] FULL = (LD + 1)'(DEPTH);

  logic [W-1:0]  buf_q [DEPTH];
  logic [LD-1:0] ptr_q;
  logic [LD:0]   fill_q, fill_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [W-1:0]  media_q;
  logic          mediaValida_q;
  logic          janelaCheia_q;

  // Sum stays in range because the oldest entry is always part of it.
  always_comb begin
    sum_d  = sum_q + SW'(tempRea) - SW'(buf_q[ptr_q]);
    fill_d = (fill_q == FULL) ? fill_q : fill_q + (LD + 1)'(1);
  end

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      ptr_q         <= '0;
      fill_q        <= '0;
      sum_q         <= '0;
      media_q       <= '0;
      mediaValida_q <= 1'b0;
      janelaCheia_q <= 1'b0;
    end else begin
      mediaValida_q <= 1'b0;
      if (amostraValida) begin
        buf_q[ptr_q]  <= tempRea;
        ptr_q         <= ptr_q + LD'(1);
        fill_q        <= fill_d;
        sum_q         <= sum_d;
        media_q       <= W'(sum_d >> LD);
        mediaValida_q <= (fill_d == FULL);
        janelaCheia_q <= (fill_d == FULL);
      end
    end
  end

  assign media       = media_q;
  assign mediaValida = mediaValida_q;
  assign janelaCheia = janelaCheia_q;

endmodule

// File: rtl/reator_monitor.sv
// Reactor temperature supervisor: moving average, escalation FSM with hysteresis
// and an acknowledged sticky alarm driving the plant actuators.
module reator_monitor
  import reator_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int LIMIAR = LIMIAR_DEF,
  parameter int HIST   = HIST_DEF,
  parameter int N_ESC  = N_ESC_DEF
) (
  input  logic         CLOCK,
  input  logic         reset,
  input  logic         amostraValida,
  input  logic [W-1:0] tempRea,
  input  logic         ackAlarme,
  output logic [W-1:0] media,
  output logic         mediaValida,
  output logic         janelaCheia,
  output logic [2:0]   estado,
  output logic         sistemaRefrigeracao,
  output logic         portasDeConcreto,
  output logic         alarmeSonoroReator
);

  localparam int CW = log2c(N_ESC + 1);
  localparam logic [CW-1:0] NESC_C  = CW'(N_ESC);
  localparam logic [31:0]   LIM_U   = 32'(LIMIAR);
  localparam logic [31:0]   BAIXO_U = 32'(LIMIAR - HIST);

  logic          alto, baixo;
  logic [2:0]    estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d, cntInc;
  logic [2:0]    atuadores_q;

  janela_media #(.W(W), .DEPTH(DEPTH)) u_janela (
    .CLOCK        (CLOCK),
    .reset        (reset),
    .amostraValida(amostraValida),
    .tempRea      (tempRea),
    .media        (media),
    .mediaValida  (mediaValida),
    .janelaCheia  (janelaCheia)
  );

  assign alto  = (32'(media) >= LIM_U);
  assign baixo = (32'(media) < BAIXO_U);

  // {refrigeration, concrete doors, siren} for a given state code.
  function automatic logic [2:0] decodeAtuadores(input logic [2:0] s);
    case (s)
      REFRIG, RESFRIANDO: return 3'b100;
      PORTAS:             return 3'b110;
      ALARME:             return 3'b111;
      default:            return 3'b000;
    endcase
  endfunction

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    cntInc   = cnt_q + CW'(1);
    if (estado_q > RESFRIANDO) begin
      estado_d = NORMAL;
      cnt_d    = '0;
    end else if (mediaValida) begin
      case (estado_q)
        NORMAL: begin
          cnt_d = '0;
          if (alto) estado_d = REFRIG;
        end
        REFRIG, PORTAS: begin
          if (alto) begin
            if (cntInc == NESC_C) begin
              estado_d = (estado_q == REFRIG) ? PORTAS : ALARME;
              cnt_d    = '0;
            end else begin
              cnt_d = cntInc;
            end
          end else begin
            cnt_d = '0;
            if (baixo) estado_d = RESFRIANDO;
          end
        end
        // Only a cool reading plus an operator ack releases the alarm.
        ALARME: begin
          cnt_d = '0;
          if (baixo && ackAlarme) estado_d = RESFRIANDO;
        end
        RESFRIANDO: begin
          if (alto) begin
            estado_d = REFRIG;
            cnt_d    = '0;
          end else if (baixo) begin
            if (cntInc == NESC_C) begin
              estado_d = NORMAL;
              cnt_d    = '0;
            end else begin
              cnt_d = cntInc;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          estado_d = NORMAL;
          cnt_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      estado_q    <= NORMAL;
      cnt_q       <= '0;
      atuadores_q <= 3'b000;
    end else begin
      estado_q    <= estado_d;
      cnt_q       <= cnt_d;
      atuadores_q <= decodeAtuadores(estado_d);
    end
  end

  assign estado              = estado_q;
  assign sistemaRefrigeracao = atuadores_q[2];
  assign portasDeConcreto    = atuadores_q[1];
  assign alarmeSonoroReator  = atuadores_q[0];

endmodule
